// File: rtl/priority_encoder_serial_if.sv
// Handshake bundle for priority_encoder_serial: vector input side and
// one-index-per-beat output side.
interface priority_encoder_serial_if #(
    parameter int N = 8
);
    localparam int W = $clog2(N);

    logic [N-1:0] in_vec;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out_idx;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;
    logic         out_none;

    modport slave (
        input  in_vec, in_valid, out_ready,
        output in_ready, out_idx, out_valid, out_last, out_none
    );

    modport master (
        output in_vec, in_valid, out_ready,
        input  in_ready, out_idx, out_valid, out_last, out_none
    );
endinterface

// File: rtl/priority_encoder_serial.sv
// Serial priority encoder: captures an N-bit request vector and emits one set index per beat.
// Define PRIO_ENC_RR_EN for round-robin selection; default is fixed lowest-index-first.
module priority_encoder_serial #(
    parameter int N = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    priority_encoder_serial_if.slave  bus
);
    localparam int W = $clog2(N);
    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] pending_q, pending_d;
    logic         zero_q, zero_d;
    logic [W-1:0] idx_q, idx_d;
    logic         valid_q, valid_d;
    logic         last_q, last_d;
    logic         none_q, none_d;

    logic [W-1:0] sel_idx;
    logic [N-1:0] pend_clr;
    logic         in_ready;
    logic         can_issue;

`ifdef PRIO_ENC_RR_EN
    logic [W-1:0] ptr_q, ptr_d;
    logic         found;
    int           j;

    // Scan upward from the pointer, wrapping, and take the first set bit.
    always_comb begin
        sel_idx = '0;
        found   = 1'b0;
        j       = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr_q) + i;
            if (j >= N) j = j - N;
            if (!found && pending_q[j]) begin
                found   = 1'b1;
                sel_idx = W'(j);
            end
        end
    end
`else
    always_comb begin
        sel_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (pending_q[i]) sel_idx = W'(i);
        end
    end
`endif

    assign pend_clr  = pending_q & ~(ONE << sel_idx);
    assign in_ready  = (pending_q == '0) && !zero_q;
    assign can_issue = !valid_q || bus.out_ready;

    always_comb begin
        pending_d = pending_q;
        zero_d    = zero_q;
        idx_d     = idx_q;
        valid_d   = valid_q;
        last_d    = last_q;
        none_d    = none_q;
`ifdef PRIO_ENC_RR_EN
        ptr_d     = ptr_q;
`endif
        if (can_issue) begin
            if (pending_q != '0) begin
                idx_d     = sel_idx;
                valid_d   = 1'b1;
                last_d    = (pend_clr == '0);
                none_d    = 1'b0;
                pending_d = pend_clr;
`ifdef PRIO_ENC_RR_EN
                ptr_d     = (int'(sel_idx) == N - 1) ? '0 : sel_idx + W'(1);
`endif
            end else if (zero_q) begin
                // All-zero vector: a single marker beat; the pointer stays put.
                idx_d   = '0;
                valid_d = 1'b1;
                last_d  = 1'b1;
                none_d  = 1'b1;
                zero_d  = 1'b0;
            end else begin
                valid_d = 1'b0;
            end
        end
        // Accept only happens when nothing is pending, so it never races an issue.
        if (bus.in_valid && in_ready) begin
            pending_d = bus.in_vec;
            zero_d    = (bus.in_vec == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            zero_q    <= 1'b0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            none_q    <= 1'b0;
`ifdef PRIO_ENC_RR_EN
            ptr_q     <= '0;
`endif
        end else begin
            pending_q <= pending_d;
            zero_q    <= zero_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            none_q    <= none_d;
`ifdef PRIO_ENC_RR_EN
            ptr_q     <= ptr_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_idx   = idx_q;
    assign bus.out_valid = valid_q;
    assign bus.out_last  = last_q;
    assign bus.out_none  = none_q;
endmodule

// File: doc/priority_encoder_serial.md
PRIORITY_ENCODER_SERIAL -- requirements
Module: priority_encoder_serial

Interface
REQ-001 The module SHALL have parameter N, default 8, number of request bits; legal N >= 2.
REQ-002 The module SHALL derive localparam W = clog2(N), the index width; it is not user-settable.
REQ-003 The module SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 The module SHALL have port in_vec  input  N  request vector; bit i requests index i.
REQ-006 The module SHALL have port in_valid  input  1  in_vec is valid this cycle.
REQ-007 The module SHALL have port in_ready  output  1  the block can accept a vector this cycle.
REQ-008 The module SHALL have port out_idx  output  W  encoded index of the current beat.
REQ-009 The module SHALL have port out_valid  output  1  out_idx, out_last and out_none are valid.
REQ-010 The module SHALL have port out_ready  input  1  the downstream consumes the beat this cycle.
REQ-011 The module SHALL have port out_last  output  1  the beat is the final beat of its vector.
REQ-012 The module SHALL have port out_none  output  1  the vector was all-zero; out_idx is 0.

Function
REQ-013 Accept: a vector SHALL be captured into an N-bit pending register when in_valid && in_ready are both high at a rising edge.
REQ-014 in_ready SHALL be 1 exactly when pending == 0 and no all-zero beat is pending; it is a function of registered state only.
REQ-015 Issue: when (!out_valid || out_ready) and pending != 0, the next edge SHALL load the selected index into out_idx, set out_valid = 1, and clear that bit in pending.
REQ-016 Selection without round-robin SHALL be the lowest set index in pending.
REQ-017 out_last SHALL be 1 on a beat when, after clearing the selected bit, pending == 0.
REQ-018 All-zero accept: the vector SHALL produce exactly one beat with out_idx = 0, out_none = 1, out_last = 1.
REQ-019 Latency: a vector accepted at edge T SHALL present its first beat at edge T+1; with out_ready held high, k set bits SHALL issue on k consecutive cycles.
REQ-020 Throughput: the next vector SHALL be accepted no earlier than the edge after the vector's last beat is loaded, giving at most one single-bit vector per 2 cycles.
REQ-021 Backpressure: while out_valid && !out_ready, out_idx, out_last, out_none and pending SHALL hold stable.
REQ-022 When out_ready is high and no new beat is issued, out_valid SHALL fall to 0 at the next edge.

Reset
REQ-023 rst_n low SHALL immediately force pending = 0, out_valid = 0, out_idx = 0, out_last = 0, out_none = 0, and the round-robin pointer = 0; in_ready = 1 while rst_n is low.
REQ-024 Reset mid-vector SHALL discard all remaining bits; no beat of that vector is issued after reset is released.

Configuration
REQ-025 With macro PRIO_ENC_RR_EN defined, selection SHALL be round-robin:
- choose the first set bit at index >= ptr, wrapping modulo N;
- after each issued beat, ptr = (issued index + 1) mod N;
- ptr persists across vectors;
- all-zero beats do not move ptr.
REQ-026 Without PRIO_ENC_RR_EN, there SHALL be no pointer register, and selection SHALL be fixed lowest-index per REQ-016.

Verification (N = 8)
REQ-027 in_vec = 8'b00000100 accepted at T -> at T+1 out_valid = 1, out_idx = 2, out_last = 1, out_none = 0; in_ready = 1 at T+2.
REQ-028 in_vec = 8'b10010010 with out_ready = 1 -> beats idx 1, 4, 7 on consecutive cycles, out_last = 1 only on idx 7.
REQ-029 Same vector with out_ready = 0 for 3 cycles after the first beat -> idx = 1 held stable for 3 cycles, then 4, 7; no beat lost or duplicated.
REQ-030 in_vec = 8'h00 -> one beat with out_idx = 0, out_none = 1, out_last = 1.
REQ-031 8'b00010010 then 8'b10100001 -> with PRIO_ENC_RR_EN: 1, 4 | 5, 7, 0; without: 1, 4 | 0, 5, 7.
REQ-032 rst_n pulsed low during the second beat of 8'b11110000 -> out_valid = 0 asynchronously, in_ready = 1; no further beats of that vector after release.
